// File: rtl/timer_pkg.sv
// Shared constants and types for the interval timer bank: clock/tick presets,
// channel mode encoding and the per-channel state type.
package timer_pkg;

  localparam int CLK_HZ_DEFAULT = 50_000_000;
  localparam int TICK_1MS       = 50000;
  localparam int TICK_100MS     = 5_000_000;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // CH_IDLE also serves as the "previous enable was low" history
  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_DONE = 2'd2
  } ch_state_e;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: counts shared base ticks up to a period latched at start,
// pulses time_out on expiry and parks in CH_DONE after a one-shot expiry.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             periodic,
  input  logic [CNT_W-1:0] period,
  input  logic             tick,
  output logic             time_out,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  // A zero period would never expire, so it is promoted to one tick
  function automatic logic [CNT_W-1:0] f_load_period(input logic [CNT_W-1:0] p);
    return (p == '0) ? CNT_W'(1) : p;
  endfunction

  ch_state_e        r_state;
  ch_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_period_q;
  logic [CNT_W-1:0] r_count;
  logic             r_mode_q;
  logic             r_time_out;
  logic             w_start;
  logic             w_run_tick;
  logic             w_expire;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= CH_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = CH_IDLE;
    end else begin
      case (r_state)
        CH_IDLE: w_state_nxt = CH_RUN;
        CH_RUN:  if (w_expire && (r_mode_q == MODE_ONESHOT)) w_state_nxt = CH_DONE;
        CH_DONE: w_state_nxt = CH_DONE;
        default: w_state_nxt = CH_IDLE;
      endcase
    end
  end

  always_comb begin
    w_start    = enable && (r_state == CH_IDLE);
    w_run_tick = enable && (r_state == CH_RUN) && tick;
    w_expire   = w_run_tick && (r_count == (r_period_q - CNT_W'(1)));
    done       = (r_state == CH_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_period_q <= '0;
      r_mode_q   <= MODE_ONESHOT;
      r_count    <= '0;
      r_time_out <= 1'b0;
    end else begin
      r_time_out <= w_expire;
      if (w_start) begin
        r_period_q <= f_load_period(period);
        r_mode_q   <= periodic;
        r_count    <= '0;
      end else if (w_expire) begin
        r_count <= '0;
      end else if (w_run_tick) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!enable || (r_state == CH_DONE)) begin
        r_count <= '0;
      end
    end
  end

  assign time_out = r_time_out;
  assign count    = r_count;

endmodule

// File: rtl/interval_timer_bank.sv
// Multi-channel interval timer: one shared prescaler produces the base tick,
// and N_CH independent channels count that tick against their own periods.
module interval_timer_bank
  import timer_pkg::*;
#(
  parameter int CLKS_PER_TICK = TICK_1MS,
  parameter int CNT_W         = 16,
  parameter int N_CH          = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_CH-1:0]       enable,
  input  logic [N_CH-1:0]       periodic,
  input  logic [N_CH*CNT_W-1:0] period,
  output logic                  tick,
  output logic [N_CH-1:0]       time_out,
  output logic [N_CH-1:0]       done,
  output logic [N_CH*CNT_W-1:0] count
);

  localparam int                PCNT_W   = $clog2(CLKS_PER_TICK);
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(CLKS_PER_TICK - 1);

  logic [PCNT_W-1:0] r_pcnt;
  logic              r_tick;
  logic              w_any_en;

  assign w_any_en = |enable;

  // Prescaler idles at zero whenever no channel runs, so a lone start is exact
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pcnt <= '0;
      r_tick <= 1'b0;
    end else if (!w_any_en) begin
      r_pcnt <= '0;
      r_tick <= 1'b0;
    end else if (r_pcnt == PCNT_MAX) begin
      r_pcnt <= '0;
      r_tick <= 1'b1;
    end else begin
      r_pcnt <= r_pcnt + PCNT_W'(1);
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable[gi]),
      .periodic (periodic[gi]),
      .period   (period[gi*CNT_W +: CNT_W]),
      .tick     (r_tick),
      .time_out (time_out[gi]),
      .done     (done[gi]),
      .count    (count[gi*CNT_W +: CNT_W])
    );
  end

endmodule
